ifetch_unit: RTL and testbench

Instruction fetch unit that produces the instruction word whose opcode, funct3 and funct7 fields drive the control decoder. It consumes the decoder's NPCOp result as resolved by the execute stage. It owns the PC register and fetches one instruction at a time from instruction memory over a valid/ready request and valid response channel. It presents each fetched instruction to decode with a valid/ready handshake, then waits for the next-PC resolution before fetching again.

---
 rtl/ifetch_unit_pkg.sv | 17 +
 rtl/ifetch_unit_npc.sv | 27 ++
 rtl/ifetch_unit.sv | 105 ++++++++++
 tb/tb_ifetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit: next-PC operations and
// the fetch FSM state type.
package ifetch_unit_pkg;

  localparam logic [4:0] NPC_PLUS4  = 5'b00000;
  localparam logic [4:0] NPC_BRANCH = 5'b00001;
  localparam logic [4:0] NPC_JUMP   = 5'b00010;
  localparam logic [4:0] NPC_JALR   = 5'b00100;

  typedef enum logic [1:0] {
    IFU_REQ     = 2'd0,
    IFU_WAIT    = 2'd1,
    IFU_HOLD    = 2'd2,
    IFU_RESOLVE = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifetch_unit_npc.sv
// Combinational next-PC selection; flags targets that are not word-aligned.
module ifu_npc
  import ifetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [4:0]  npc_op_i,
  input  logic        br_taken_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_data_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    case (npc_op_i)
      NPC_BRANCH: if (br_taken_i) next_pc_o = pc_i + imm_i;
      NPC_JUMP:   next_pc_o = pc_i + imm_i;
      NPC_JALR:   next_pc_o = (rs1_data_i + imm_i) & 32'hFFFF_FFFE;
      default:    ;
    endcase
  end

  // JALR clears only bit 0, so bit 1 can still leave a misaligned target.
  assign misalign_o = |next_pc_o[1:0];

endmodule

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch: request, wait for response, hold for
// decode, then wait for the execute stage's next-PC decision.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [6:0]  Op,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  input  logic        resolve_valid,
  input  logic [4:0]  NPCOp,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic        misalign_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the valid side keeps its payload stable until that edge.
  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        err_q;
  logic [31:0] next_pc;
  logic        misalign;

  ifu_npc u_npc (
    .pc_i       (pc_q),
    .npc_op_i   (NPCOp),
    .br_taken_i (br_taken),
    .imm_i      (imm),
    .rs1_data_i (rs1_data),
    .next_pc_o  (next_pc),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IFU_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IFU_REQ: begin
          if (imem_req_ready) state_q <= IFU_WAIT;
        end
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            inst_q    <= imem_rsp_data;
            inst_pc_q <= pc_q;
            state_q   <= IFU_HOLD;
          end
        end
        IFU_HOLD: begin
          // A same-cycle resolve skips RESOLVE for the 3-cycle best case.
          if (inst_ready) begin
            if (resolve_valid) begin
              pc_q    <= next_pc;
              err_q   <= err_q | misalign;
              state_q <= IFU_REQ;
            end else begin
              state_q <= IFU_RESOLVE;
            end
          end
        end
        IFU_RESOLVE: begin
          if (resolve_valid) begin
            pc_q    <= next_pc;
            err_q   <= err_q | misalign;
            state_q <= IFU_REQ;
          end
        end
        default: state_q <= IFU_REQ;
      endcase
    end
  end

  assign imem_req_valid = (state_q == IFU_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == IFU_HOLD);
  assign inst_out       = inst_q;
  assign inst_pc        = inst_pc_q;
  assign Op             = inst_q[6:0];
  assign Funct3         = inst_q[14:12];
  assign Funct7         = inst_q[31:25];
  assign misalign_err   = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a table of fetch/resolve records plus a
// hand-written reset-during-WAIT sequence.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic        resolve_valid;
  logic [4:0]  NPCOp;
  logic        br_taken;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        misalign_err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  op;
    logic        br;
    logic [31:0] imm;
    logic [31:0] rs1;
    int          req_stall;
    int          rsp_delay;
    int          ready_delay;
    int          res_delay;
    logic [31:0] exp_next;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  ifetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .Op             (Op),
    .Funct3         (Funct3),
    .Funct7         (Funct7),
    .resolve_valid  (resolve_valid),
    .NPCOp          (NPCOp),
    .br_taken       (br_taken),
    .imm            (imm),
    .rs1_data       (rs1_data),
    .misalign_err   (misalign_err),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] cur_pc;
    logic [31:0] prev_inst;
    logic [31:0] w;
    vec_t        v;

    //          inst          op          br    imm            rs1           stl rsp rdy res exp_next       err
    vecs[0]  = '{32'h0050_0093, NPC_PLUS4,  1'b0, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 32'h0000_0104, 1'b0};
    vecs[1]  = '{32'h0FC0_006F, NPC_JUMP,   1'b0, 32'h0000_00FC, 32'h0,        5, 0, 0, 0, 32'h0000_0200, 1'b0};
    vecs[2]  = '{32'hFE00_0CE3, NPC_BRANCH, 1'b1, 32'hFFFF_FFF8, 32'h0,        0, 0, 4, 3, 32'h0000_01F8, 1'b0};
    vecs[3]  = '{32'h0080_006F, NPC_JUMP,   1'b0, 32'h0000_0008, 32'h0,        0, 2, 0, 0, 32'h0000_0200, 1'b0};
    vecs[4]  = '{32'hFE00_1CE3, NPC_BRANCH, 1'b0, 32'hFFFF_FFF8, 32'h0,        0, 0, 0, 1, 32'h0000_0204, 1'b0};
    vecs[5]  = '{32'h4020_8033, 5'b11111,   1'b1, 32'h0000_1000, 32'h0,        1, 1, 0, 0, 32'h0000_0208, 1'b0};
    vecs[6]  = '{32'h0000_0863, NPC_BRANCH, 1'b1, 32'h0000_0010, 32'h0,        0, 0, 1, 0, 32'h0000_0218, 1'b0};
    vecs[7]  = '{32'h5DD0_006F, NPC_JUMP,   1'b0, 32'hFFFF_FDD8, 32'h0,        0, 0, 0, 0, 32'hFFFF_FFF0, 1'b0};
    vecs[8]  = '{32'h0200_006F, NPC_JUMP,   1'b0, 32'h0000_0020, 32'h0,        0, 0, 2, 0, 32'h0000_0010, 1'b0};
    vecs[9]  = '{32'h0040_80E7, NPC_JALR,   1'b0, 32'h0000_0004, 32'h0000_1003, 0, 0, 0, 0, 32'h0000_1006, 1'b1};
    vecs[10] = '{32'h00C1_2023, NPC_PLUS4,  1'b0, 32'h0000_0000, 32'h0,        0, 0, 0, 2, 32'h0000_100A, 1'b1};
    vecs[11] = '{32'h0000_7033, NPC_PLUS4,  1'b0, 32'h0000_0000, 32'h0,        0, 1, 0, 0, 32'h0000_100E, 1'b1};

    rstn = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    inst_ready = 1'b0;
    resolve_valid = 1'b0;
    NPCOp = NPC_PLUS4;
    br_taken = 1'b0;
    imm = 32'h0;
    rs1_data = 32'h0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    chk("rst_state", 32'(dbg_state), 32'(IFU_REQ));
    chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0100);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_err", 32'(misalign_err), 32'd0);

    cur_pc = 32'h0000_0100;
    prev_inst = 32'h0;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      chk("req_valid", 32'(imem_req_valid), 32'd1);
      chk("req_addr", imem_req_addr, cur_pc);

      if (v.req_stall > 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        for (int k = 0; k < v.req_stall; k++) begin
          @(negedge clk);
          imem_rsp_valid = 1'b0;
          chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
          chk("stall_req_addr", imem_req_addr, cur_pc);
        end
        chk("spurious_rsp", inst_out, prev_inst);
      end

      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk("wait_state", 32'(dbg_state), 32'(IFU_WAIT));

      if (v.rsp_delay > 0) begin
        resolve_valid = 1'b1;
        NPCOp = NPC_JUMP;
        imm = 32'h0000_0040;
        for (int k = 0; k < v.rsp_delay; k++) begin
          @(negedge clk);
          chk("wait_inst_valid", 32'(inst_valid), 32'd0);
        end
        resolve_valid = 1'b0;
      end

      imem_rsp_valid = 1'b1;
      imem_rsp_data = v.inst;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0;

      w = v.inst;
      chk("hold_inst_valid", 32'(inst_valid), 32'd1);
      chk("hold_req_valid", 32'(imem_req_valid), 32'd0);
      chk("inst_out", inst_out, w);
      chk("inst_pc", inst_pc, cur_pc);
      chk("op", 32'(Op), 32'(w[6:0]));
      chk("funct3", 32'(Funct3), 32'(w[14:12]));
      chk("funct7", 32'(Funct7), 32'(w[31:25]));

      for (int k = 0; k < v.ready_delay; k++) begin
        @(negedge clk);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        chk("stall_inst_out", inst_out, w);
        chk("stall_inst_pc", inst_pc, cur_pc);
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      end

      inst_ready = 1'b1;
      NPCOp = v.op;
      br_taken = v.br;
      imm = v.imm;
      rs1_data = v.rs1;
      if (v.res_delay == 0) begin
        resolve_valid = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        resolve_valid = 1'b0;
      end else begin
        @(negedge clk);
        inst_ready = 1'b0;
        chk("resolve_state", 32'(dbg_state), 32'(IFU_RESOLVE));
        for (int k = 1; k < v.res_delay; k++) begin
          @(negedge clk);
          chk("resolve_no_req", 32'(imem_req_valid), 32'd0);
        end
        resolve_valid = 1'b1;
        @(negedge clk);
        resolve_valid = 1'b0;
      end

      chk("next_req_valid", 32'(imem_req_valid), 32'd1);
      chk("next_req_addr", imem_req_addr, v.exp_next);
      chk("misalign_err", 32'(misalign_err), 32'(v.exp_err));
      cur_pc = v.exp_next;
      prev_inst = v.inst;
    end

    // Reset asserted while waiting for a response; a late response is dropped.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("rw_wait_state", 32'(dbg_state), 32'(IFU_WAIT));
    #1 rstn = 1'b0;
    #1;
    chk("rw_state", 32'(dbg_state), 32'(IFU_REQ));
    chk("rw_addr", imem_req_addr, 32'h0000_0100);
    chk("rw_inst_valid", 32'(inst_valid), 32'd0);
    chk("rw_err", 32'(misalign_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("rw_post_state", 32'(dbg_state), 32'(IFU_REQ));
    chk("rw_post_inst", inst_out, 32'h0);
    chk("rw_post_addr", imem_req_addr, 32'h0000_0100);
    chk("rw_post_req_valid", 32'(imem_req_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
